// File: rtl/keypad_scanner.sv
//------------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 active-low key matrix, debounces the result and presents an
// 8-bit key code with a registered, glitch-free level `pressed` flag for the
// calculator FSM. One column is driven low at a time for SCAN_DIV cycles; the
// synchronised rows are sampled once per dwell, on the last dwell cycle.
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst        in   1  asynchronous active-low reset
//   row        in   4  matrix rows, active-low, asynchronous to clk
//   col        out  4  column drive, active-low, one-hot-zero
//   key_code   out  8  encoded key, 8'hFF when no key is held
//   pressed    out  1  high while a debounced key is held
//   key_valid  out  1  one-cycle pulse when a press is accepted
//
// Parameters
//   SCAN_DIV        dwell per column in clocks (>= 4, so that the row
//                   synchroniser settles before the dwell's sample)
//   DEBOUNCE_CNT    consecutive equal samples to accept press/release (1..255)
//   REPEAT_SAMPLES  held samples before an auto-repeat
//
// Optional feature
//   KEYPAD_REPEAT_EN  when defined, held digit keys auto-repeat: `pressed`
//                     drops for one dwell and reasserts with a key_valid pulse.
//------------------------------------------------------------------------------
module keypad_scanner #(
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_CNT   = 8,
   parameter int REPEAT_SAMPLES = 250
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [7:0] key_code,
   output logic       pressed,
   output logic       key_valid
);

   localparam int              DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DW-1:0]   DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [DW-1:0]   DWELL_ONE  = {{(DW-1){1'b0}}, 1'b1};
   localparam logic [DW-1:0]   DWELL_ZERO = {DW{1'b0}};
   localparam logic [7:0]      DEB_LIM    = 8'(DEBOUNCE_CNT);
   localparam logic [7:0]      KEY_IDLE   = 8'hFF;
   localparam logic [3:0]      ROW_IDLE   = 4'hF;
   localparam logic [3:0]      COL_RESET  = 4'b1110;

   // Reject parameter values the scan/debounce timing cannot honour.
   if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || DEBOUNCE_CNT > 255 || REPEAT_SAMPLES < 1) begin : g_param_check
      $error("keypad_scanner: parameter out of range");
   end

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HOLD     = 2'd2,
      ST_RLOW     = 2'd3   // auto-repeat low phase, reachable only with repeat enabled
   } state_t;

   // True when exactly one bit of an active-low nibble is low.
   function automatic logic one_low(input logic [3:0] p);
      case (p)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
         default:                            one_low = 1'b0;
      endcase
   endfunction

   // Index of the low bit of a one-hot-zero nibble.
   function automatic logic [1:0] low_idx(input logic [3:0] p);
      case (p)
         4'b1110: low_idx = 2'd0;
         4'b1101: low_idx = 2'd1;
         4'b1011: low_idx = 2'd2;
         4'b0111: low_idx = 2'd3;
         default: low_idx = 2'd0;
      endcase
   endfunction

   // Key map: {row, col} -> code.
   function automatic logic [7:0] map_key(input logic [1:0] r, input logic [1:0] c);
      case ({r, c})
         4'h0:    map_key = 8'h01;
         4'h1:    map_key = 8'h02;
         4'h2:    map_key = 8'h03;
         4'h3:    map_key = 8'hF0;
         4'h4:    map_key = 8'h04;
         4'h5:    map_key = 8'h05;
         4'h6:    map_key = 8'h06;
         4'h7:    map_key = 8'hF1;
         4'h8:    map_key = 8'h07;
         4'h9:    map_key = 8'h08;
         4'hA:    map_key = 8'h09;
         4'hB:    map_key = 8'hF2;
         4'hC:    map_key = 8'hFC;
         4'hD:    map_key = 8'h00;
         4'hE:    map_key = 8'hFD;
         4'hF:    map_key = 8'hF3;
         default: map_key = KEY_IDLE;
      endcase
   endfunction

   logic [3:0]    row_meta_q, row_sync_q;
   logic [DW-1:0] dwell_q, dwell_d;
   state_t        state_q, state_d;
   logic [3:0]    col_q, col_d;
   logic [3:0]    row_pat_q, row_pat_d;
   logic [7:0]    deb_cnt_q, deb_cnt_d;
   logic [7:0]    key_code_q, key_code_d;
   logic          pressed_q, pressed_d;
   logic          key_valid_q, key_valid_d;
   logic          sample_s;
   logic [7:0]    deb_inc_s;
   logic [3:0]    col_next_s;
   logic [7:0]    accept_code_s;
`ifdef KEYPAD_REPEAT_EN
   localparam logic [15:0] REP_LIM = 16'(REPEAT_SAMPLES);
   logic [15:0]   rep_cnt_q, rep_cnt_d;
   logic [15:0]   rep_inc_s;
`endif

   assign sample_s  = (dwell_q == DWELL_LAST);
   assign col       = col_q;
   assign key_code  = key_code_q;
   assign pressed   = pressed_q;
   assign key_valid = key_valid_q;

   // Two-flop synchroniser for the asynchronous row inputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_meta_q <= ROW_IDLE;
         row_sync_q <= ROW_IDLE;
      end else begin
         row_meta_q <= row;
         row_sync_q <= row_meta_q;
      end
   end

   // Dwell counter: wraps after the sampling cycle.
   always_comb begin
      dwell_d = dwell_q;
      if (sample_s) begin
         dwell_d = DWELL_ZERO;
      end else begin
         dwell_d = dwell_q + DWELL_ONE;
      end
   end

   // Scanner state and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dwell_q     <= DWELL_ZERO;
         state_q     <= ST_SCAN;
         col_q       <= COL_RESET;
         row_pat_q   <= ROW_IDLE;
         deb_cnt_q   <= 8'd0;
         key_code_q  <= KEY_IDLE;
         pressed_q   <= 1'b0;
         key_valid_q <= 1'b0;
      end else begin
         dwell_q     <= dwell_d;
         state_q     <= state_d;
         col_q       <= col_d;
         row_pat_q   <= row_pat_d;
         deb_cnt_q   <= deb_cnt_d;
         key_code_q  <= key_code_d;
         pressed_q   <= pressed_d;
         key_valid_q <= key_valid_d;
      end
   end

`ifdef KEYPAD_REPEAT_EN
   // Auto-repeat sample counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rep_cnt_q <= 16'd0;
      end else begin
         rep_cnt_q <= rep_cnt_d;
      end
   end
`endif

   // Next-state and output logic; everything moves only on a sample cycle.
   always_comb begin
      state_d       = state_q;
      col_d         = col_q;
      row_pat_d     = row_pat_q;
      deb_cnt_d     = deb_cnt_q;
      key_code_d    = key_code_q;
      pressed_d     = pressed_q;
      key_valid_d   = 1'b0;
      deb_inc_s     = deb_cnt_q + 8'd1;
      col_next_s    = {col_q[2:0], col_q[3]};
      // The column is frozen once a candidate is latched, so col_q names the key column.
      accept_code_s = map_key(low_idx(row_sync_q), low_idx(col_q));
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_d     = rep_cnt_q;
      rep_inc_s     = rep_cnt_q + 16'd1;
`endif
      if (sample_s) begin
         case (state_q)
            ST_SCAN: begin
               if (row_sync_q == ROW_IDLE) begin
                  col_d = col_next_s;
               end else if (one_low(row_sync_q)) begin
                  row_pat_d = row_sync_q;
                  // The detecting sample is the first of the debounce run.
                  if (DEB_LIM == 8'd1) begin
                     state_d     = ST_HOLD;
                     deb_cnt_d   = 8'd0;
                     key_code_d  = accept_code_s;
                     pressed_d   = 1'b1;
                     key_valid_d = 1'b1;
                  end else begin
                     state_d   = ST_DEBOUNCE;
                     deb_cnt_d = 8'd1;
                  end
               end else begin
                  // Several keys in one column are ambiguous: skip this column.
                  col_d = col_next_s;
               end
            end
            ST_DEBOUNCE: begin
               if (row_sync_q == row_pat_q) begin
                  if (deb_inc_s == DEB_LIM) begin
                     state_d     = ST_HOLD;
                     deb_cnt_d   = 8'd0;
                     key_code_d  = accept_code_s;
                     pressed_d   = 1'b1;
                     key_valid_d = 1'b1;
                  end else begin
                     deb_cnt_d = deb_inc_s;
                  end
               end else begin
                  state_d   = ST_SCAN;
                  col_d     = col_next_s;
                  deb_cnt_d = 8'd0;
               end
            end
            ST_HOLD: begin
               if (row_sync_q == ROW_IDLE) begin
`ifdef KEYPAD_REPEAT_EN
                  rep_cnt_d = 16'd0;
`endif
                  if (deb_inc_s == DEB_LIM) begin
                     state_d    = ST_SCAN;
                     col_d      = col_next_s;
                     deb_cnt_d  = 8'd0;
                     key_code_d = KEY_IDLE;
                     pressed_d  = 1'b0;
                  end else begin
                     deb_cnt_d = deb_inc_s;
                  end
               end else begin
                  // Any non-idle sample restarts release qualification.
                  deb_cnt_d = 8'd0;
`ifdef KEYPAD_REPEAT_EN
                  if (!key_code_q[7]) begin
                     if (rep_inc_s == REP_LIM) begin
                        state_d   = ST_RLOW;
                        pressed_d = 1'b0;
                        rep_cnt_d = 16'd0;
                     end else begin
                        rep_cnt_d = rep_inc_s;
                     end
                  end else begin
                     rep_cnt_d = 16'd0;
                  end
`endif
               end
            end
`ifdef KEYPAD_REPEAT_EN
            ST_RLOW: begin
               // One dwell has passed with pressed low.
               rep_cnt_d = 16'd0;
               deb_cnt_d = 8'd0;
               if (row_sync_q == ROW_IDLE) begin
                  // Released during the gap: the key is already reported up.
                  state_d    = ST_SCAN;
                  col_d      = col_next_s;
                  key_code_d = KEY_IDLE;
               end else begin
                  state_d     = ST_HOLD;
                  pressed_d   = 1'b1;
                  key_valid_d = 1'b1;
               end
            end
`endif
            default: begin
               state_d    = ST_SCAN;
               col_d      = COL_RESET;
               deb_cnt_d  = 8'd0;
               key_code_d = KEY_IDLE;
               pressed_d  = 1'b0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;
   localparam int SD  = 4;
   localparam int DEB = 3;
   localparam int REP = 5;
   localparam int PRESS_BUDGET   = 2 + 4*SD + DEB*SD;
   localparam int RELEASE_BUDGET = 2 + DEB*SD;
`ifdef KEYPAD_REPEAT_EN
   localparam int EXP_FALLS = 2;
`else
   localparam int EXP_FALLS = 0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] row;
   logic [3:0] col;
   logic [7:0] key_code;
   logic       pressed;
   logic       key_valid;
   logic [15:0] key_down = 16'h0000;
   logic [7:0]  codes [16];
   logic [7:0]  exp_q [$];
   int checks = 0;
   int passed = 0;

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DEB), .REPEAT_SAMPLES(REP)) dut (
      .clk(clk), .rst(rst), .row(row), .col(col),
      .key_code(key_code), .pressed(pressed), .key_valid(key_valid)
   );

   always #5 clk = ~clk;

   // Physical matrix: a held key shorts its row to its column's drive.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (key_down[r*4+c] && !col[c]) row[r] = 1'b0;
   end

   task automatic check(input bit ok, input string name, input int act, input int exp);
      checks++;
      if (ok) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [3:0] col_of(input int k);
      logic [3:0] m;
      m = 4'b0001 << (k % 4);
      return ~m;
   endfunction

   // Scoreboard monitor: each accepted press must match the next expectation.
   always @(negedge clk) begin
      if (rst && key_valid) begin
         check(exp_q.size() != 0, "unexpected_key_valid", key_code, 8'hFF);
         if (exp_q.size() != 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            check(key_code == e, "valid_code", key_code, e);
            check(pressed == 1'b1, "valid_pressed", pressed, 1);
         end
      end
   end

   task automatic wait_level(input logic lvl, input int budget, input string name);
      int n = 0;
      while (pressed !== lvl && n < budget) begin
         @(posedge clk); #1; n++;
      end
      check(pressed === lvl, name, pressed, lvl);
   endtask

   task automatic hold_watch(input int cycles, input logic [7:0] code,
                             output int falls, output int bad_low, output int bad_code);
      int run = 0;
      logic prev = 1'b1;
      falls = 0; bad_low = 0; bad_code = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (key_code !== code) bad_code++;
         if (!pressed) begin
            if (prev) falls++;
            run++;
         end else begin
            if (!prev && run != SD) bad_low++;
            run = 0;
         end
         prev = pressed;
      end
   endtask

   // Full press/hold/release of one key with scoreboard expectation.
   task automatic press_release(input int k, input int hold, input string name);
      exp_q.push_back(codes[k]);
      key_down[k] = 1'b1;
      wait_level(1'b1, PRESS_BUDGET, {name, "_press"});
      check(key_code == codes[k], {name, "_code"}, key_code, codes[k]);
      check(col == col_of(k), {name, "_col_frozen"}, col, col_of(k));
      repeat (hold) @(posedge clk);
      #1;
      key_down[k] = 1'b0;
      wait_level(1'b0, RELEASE_BUDGET, {name, "_release"});
      check(key_code == 8'hFF, {name, "_idle_code"}, key_code, 8'hFF);
   endtask

   initial begin
      int falls, bad_low, bad_code, hi;
      logic [3:0] ec;
      codes = '{8'h01, 8'h02, 8'h03, 8'hF0, 8'h04, 8'h05, 8'h06, 8'hF1,
                8'h07, 8'h08, 8'h09, 8'hF2, 8'hFC, 8'h00, 8'hFD, 8'hF3};

      // Reset and idle scan
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check(col == 4'b1110, "rst_col", col, 4'b1110);
      check(key_code == 8'hFF, "rst_code", key_code, 8'hFF);
      check(pressed == 1'b0, "rst_pressed", pressed, 0);
      check(key_valid == 1'b0, "rst_valid", key_valid, 0);
      @(negedge clk) rst = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         repeat (SD) @(posedge clk);
         #1;
         ec = col_of(i);
         check(col == ec, "idle_col_rotate", col, ec);
      end

      // Clean press of '5'
      press_release(5, 3, "key5");

      // Randomised presses
      for (int i = 0; i < 8; i++) begin
         int k;
         k = $urandom_range(0, 15);
         repeat ($urandom_range(0, 7)) @(posedge clk);
         #1;
         press_release(k, $urandom_range(0, 10), "rand");
      end

      // Bouncy '=' press: no acceptance while bouncing
      for (int i = 0; i < 14; i++) begin
         key_down[14] = ~key_down[14];
         repeat (3) @(posedge clk);
         #1;
      end
      check(pressed == 1'b0, "bounce_quiet", pressed, 0);
      press_release(14, 2, "bounce_eq");

      // Release bounce on 'C': one idle sample must not release
      exp_q.push_back(8'hFC);
      key_down[12] = 1'b1;
      wait_level(1'b1, PRESS_BUDGET, "c_press");
      repeat (2) @(posedge clk);
      #1;
      key_down[12] = 1'b0;
      repeat (SD) @(posedge clk);
      #1;
      key_down[12] = 1'b1;
      hold_watch(24, 8'hFC, falls, bad_low, bad_code);
      check(falls == 0, "c_release_bounce", falls, 0);
      key_down[12] = 1'b0;
      wait_level(1'b0, RELEASE_BUDGET, "c_release");
      check(key_code == 8'hFF, "c_idle_code", key_code, 8'hFF);

      // Multi-key in one column ('1' and '4'): ignored
      key_down[0] = 1'b1;
      key_down[4] = 1'b1;
      hi = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         if (pressed) hi++;
      end
      check(hi == 0, "multikey_ignored", hi, 0);
      key_down[0] = 1'b0;
      key_down[4] = 1'b0;
      repeat (8) @(posedge clk);
      #1;

      // Reset mid-hold of '+'
      exp_q.push_back(8'hF0);
      key_down[3] = 1'b1;
      wait_level(1'b1, PRESS_BUDGET, "plus_press");
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      #1;
      check(pressed == 1'b0, "async_rst_pressed", pressed, 0);
      check(key_code == 8'hFF, "async_rst_code", key_code, 8'hFF);
      check(col == 4'b1110, "async_rst_col", col, 4'b1110);
      @(negedge clk) rst = 1'b1;
      exp_q.push_back(8'hF0);
      wait_level(1'b1, PRESS_BUDGET, "plus_reaccept");
      check(key_code == 8'hF0, "plus_reaccept_code", key_code, 8'hF0);
      key_down[3] = 1'b0;
      wait_level(1'b0, RELEASE_BUDGET, "plus_release");

      // Long hold of digit '7': repeats only with the optional feature
      exp_q.push_back(8'h07);
      key_down[8] = 1'b1;
      wait_level(1'b1, PRESS_BUDGET, "seven_press");
      for (int i = 0; i < EXP_FALLS; i++) exp_q.push_back(8'h07);
      hold_watch(60, 8'h07, falls, bad_low, bad_code);
      check(falls == EXP_FALLS, "seven_repeat_count", falls, EXP_FALLS);
      check(bad_low == 0, "seven_low_width", bad_low, 0);
      check(bad_code == 0, "seven_code_held", bad_code, 0);
      key_down[8] = 1'b0;
      wait_level(1'b0, RELEASE_BUDGET, "seven_release");

      // Long hold of operator '*': never repeats
      exp_q.push_back(8'hF2);
      key_down[11] = 1'b1;
      wait_level(1'b1, PRESS_BUDGET, "star_press");
      hold_watch(60, 8'hF2, falls, bad_low, bad_code);
      check(falls == 0, "star_no_repeat", falls, 0);
      key_down[11] = 1'b0;
      wait_level(1'b0, RELEASE_BUDGET, "star_release");

      repeat (4) @(posedge clk);
      check(exp_q.size() == 0, "leftover_expect", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
